// File: rtl/rv8_pipe_pkg.sv
// Shared constants for the 8-bit RISC-V pipeline: ALU control codes, ALUOp and funct3 encodings.
package rv8_pipe_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7[5] to ALU control decode with an illegal-encoding flag.
module alu_ctrl_decode
  import rv8_pipe_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_MEM:    alu_control = ALU_ADD;
      ALUOP_BRANCH: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // Only R-type honours bit 30; there is no subtract-immediate.
          F3_ADDSUB: alu_control = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_control = ALU_AND;
          F3_OR:     alu_control = ALU_OR;
          default: begin
            alu_control = ALU_ILLEGAL;
            illegal     = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX register: decodes the ALU control code and registers it with operands, rd and write enable.
module id_ex_alu_ctrl
  import rv8_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              illegal_op,
  output logic [7:0]        illegal_count
);

  logic [3:0] dec_code;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .alu_op      (id_alu_op),
    .funct3      (id_funct3),
    .funct7b5    (id_funct7b5),
    .alu_control (dec_code),
    .illegal     (dec_illegal)
  );

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // ID -> EX boundary: flush beats stall, stall beats load; invalid ID loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= ALU_ADD;
      ex_data1       <= '0;
      ex_data2       <= '0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      illegal_op     <= 1'b0;
      illegal_count  <= 8'd0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= ALU_ADD;
      ex_data1       <= '0;
      ex_data2       <= '0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      illegal_op     <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= 1'b1;
      ex_alu_control <= dec_code;
      ex_data1       <= id_data1;
      ex_data2       <= id_data2;
      ex_rd          <= id_rd;
      ex_reg_write   <= id_reg_write & ~dec_illegal;
      illegal_op     <= dec_illegal;
      if (dec_illegal) illegal_count <= sat_inc(illegal_count);
    end
  end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_ex_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [1:0] id_alu_op = 2'b00;
  logic [2:0] id_funct3 = 3'b000;
  logic       id_funct7b5 = 1'b0;
  logic [7:0] id_data1 = 8'h00;
  logic [7:0] id_data2 = 8'h00;
  logic [4:0] id_rd = 5'd0;
  logic       id_reg_write = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       ex_valid;
  logic [3:0] ex_alu_control;
  logic [7:0] ex_data1;
  logic [7:0] ex_data2;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       illegal_op;
  logic [7:0] illegal_count;

  int n_chk = 0;
  int n_fail = 0;

  id_ex_alu_ctrl #(.DATA_W(8), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_alu_op      (id_alu_op),
    .id_funct3      (id_funct3),
    .id_funct7b5    (id_funct7b5),
    .id_data1       (id_data1),
    .id_data2       (id_data2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_data1       (ex_data1),
    .ex_data2       (ex_data2),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .illegal_op     (illegal_op),
    .illegal_count  (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: returns {illegal, code}, written from the opcode table.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'd0) return {1'b0, 4'h2};
    if (op == 2'd1) return {1'b0, 4'h6};
    if (f3 == 3'd7) return {1'b0, 4'h0};
    if (f3 == 3'd6) return {1'b0, 4'h1};
    if (f3 == 3'd0) return {1'b0, (op == 2'd2 && f7) ? 4'h6 : 4'h2};
    return {1'b1, 4'hF};
  endfunction

  logic       m_valid = 1'b0;
  logic [3:0] m_code = 4'h2;
  logic [7:0] m_d1 = 8'h00;
  logic [7:0] m_d2 = 8'h00;
  logic [4:0] m_rd = 5'd0;
  logic       m_rw = 1'b0;
  logic       m_ill = 1'b0;
  int         m_cnt = 0;

  task automatic m_bubble();
    m_valid = 1'b0; m_code = 4'h2; m_d1 = 8'h00; m_d2 = 8'h00;
    m_rd = 5'd0; m_rw = 1'b0; m_ill = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] r;
    if (!rst_n) begin
      m_bubble();
      m_cnt = 0;
    end else if (flush) begin
      m_bubble();
    end else if (!stall) begin
      if (!id_valid) m_bubble();
      else begin
        r = ref_decode(id_alu_op, id_funct3, id_funct7b5);
        m_valid = 1'b1; m_code = r[3:0]; m_d1 = id_data1; m_d2 = id_data2;
        m_rd = id_rd; m_rw = id_reg_write && !r[4]; m_ill = r[4];
        if (r[4]) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("m_code", {28'd0, ex_alu_control}, {28'd0, m_code});
    chk("m_data1", {24'd0, ex_data1}, {24'd0, m_d1});
    chk("m_data2", {24'd0, ex_data2}, {24'd0, m_d2});
    chk("m_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    chk("m_rw", {31'd0, ex_reg_write}, {31'd0, m_rw});
    chk("m_illop", {31'd0, illegal_op}, {31'd0, m_ill});
    chk("m_count", {24'd0, illegal_count}, m_cnt);
  end

  // Drive one cycle of ID inputs, then return just after the capturing edge.
  task automatic apply(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [4:0] rd,
                       input logic rw, input logic st, input logic fl);
    id_valid = v; id_alu_op = op; id_funct3 = f3; id_funct7b5 = f7;
    id_data1 = d1; id_data2 = d2; id_rd = rd; id_reg_write = rw;
    stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_code", {28'd0, ex_alu_control}, 32'h2);
    chk("rst_count", {24'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", {31'd0, ex_valid}, 32'd0);
    chk("rel_code", {28'd0, ex_alu_control}, 32'h2);

    apply(1, 2'b10, 3'b000, 1, 8'h10, 8'h03, 5'd5, 1, 0, 0);
    chk("sub_code", {28'd0, ex_alu_control}, 32'h6);
    chk("sub_d1", {24'd0, ex_data1}, 32'h10);
    chk("sub_d2", {24'd0, ex_data2}, 32'h03);
    chk("sub_rd", {27'd0, ex_rd}, 32'd5);
    chk("sub_rw", {31'd0, ex_reg_write}, 32'd1);

    apply(1, 2'b11, 3'b000, 1, 8'h22, 8'h01, 5'd6, 1, 0, 0);
    chk("itype_add", {28'd0, ex_alu_control}, 32'h2);
    apply(1, 2'b01, 3'b101, 0, 8'h22, 8'h01, 5'd0, 0, 0, 0);
    chk("branch_sub", {28'd0, ex_alu_control}, 32'h6);

    apply(1, 2'b10, 3'b110, 0, 8'hA5, 8'h5A, 5'd9, 1, 0, 0);
    chk("or_code", {28'd0, ex_alu_control}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      apply(1, 2'b10, 3'b111, 0, 8'h11 + 8'(i), 8'h77, 5'd3, 1, 1, 0);
      chk("stall_code", {28'd0, ex_alu_control}, 32'h1);
      chk("stall_d1", {24'd0, ex_data1}, 32'hA5);
    end
    apply(1, 2'b10, 3'b111, 0, 8'h11, 8'h77, 5'd3, 1, 1, 1);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);

    apply(1, 2'b10, 3'b001, 0, 8'h01, 8'h02, 5'd7, 1, 0, 0);
    chk("ill_code", {28'd0, ex_alu_control}, 32'hF);
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    chk("ill_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
    chk("ill_count", {24'd0, illegal_count}, 32'd1);
    apply(0, 2'b10, 3'b001, 0, 8'h01, 8'h02, 5'd7, 1, 0, 0);
    chk("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
    apply(1, 2'b11, 3'b010, 0, 8'h01, 8'h02, 5'd7, 1, 1, 1);
    chk("flush_ill_cnt", {24'd0, illegal_count}, 32'd1);
    for (int i = 0; i < 300; i++)
      apply(1, 2'b11, 3'b011, 0, 8'h00, 8'h00, 5'd1, 1, 0, 0);
    chk("sat_count", {24'd0, illegal_count}, 32'd255);

    apply(1, 2'b10, 3'b000, 0, 8'h33, 8'h44, 5'd2, 1, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_code", {28'd0, ex_alu_control}, 32'h2);
    chk("arst_illop", {31'd0, illegal_op}, 32'd0);
    chk("arst_count", {24'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;

    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 9) < 8, 2'($urandom), 3'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 5'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
